// File: rtl/calc_nport_core.sv
// N-port calculator: two-cycle requests are queued per port and executed
// one per cycle under round-robin arbitration, with a registered response.
module calc_nport_core #(
    parameter int NPORTS = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 2,
    parameter int QDEPTH = 4
) (
    input  logic                     c_clk,
    input  logic                     reset,
    input  logic [NPORTS*4-1:0]      req_cmd_in,
    input  logic [NPORTS*DATA_W-1:0] req_data_in,
    input  logic [NPORTS*TAG_W-1:0]  req_tag_in,
    output logic [NPORTS*2-1:0]      out_resp,
    output logic [NPORTS*DATA_W-1:0] out_data,
    output logic [NPORTS*TAG_W-1:0]  out_tag,
    output logic [NPORTS-1:0]        q_ovf
);
    localparam int RW = $clog2(NPORTS);
    localparam int PW = $clog2(QDEPTH);
    localparam int SW = $clog2(DATA_W);
    localparam logic [1:0] RESP_OK  = 2'd1;
    localparam logic [1:0] RESP_ERR = 2'd2;

    logic [NPORTS-1:0] nonempty;
    logic [3:0]        head_cmd [NPORTS];
    logic [TAG_W-1:0]  head_tag [NPORTS];
    logic [DATA_W-1:0] head_op1 [NPORTS];
    logic [DATA_W-1:0] head_op2 [NPORTS];

    logic [RW-1:0] rr;
    logic          gnt_valid;
    logic [RW-1:0] gnt_port;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        logic              busy;
        logic [3:0]        cap_cmd;
        logic [TAG_W-1:0]  cap_tag;
        logic [DATA_W-1:0] cap_op1;
        logic [PW-1:0]     wp;
        logic [PW-1:0]     rp;
        logic [PW:0]       cnt;
        logic              ovf;
        logic [3:0]        m_cmd [QDEPTH];
        logic [TAG_W-1:0]  m_tag [QDEPTH];
        logic [DATA_W-1:0] m_op1 [QDEPTH];
        logic [DATA_W-1:0] m_op2 [QDEPTH];
        logic              full;
        logic              push;
        logic              pop;
        logic [3:0]        cmd;

        assign cmd  = req_cmd_in[p*4 +: 4];
        // Fullness is judged on the count before this cycle's pop.
        assign full = (cnt == (PW+1)'(QDEPTH));
        assign push = busy && !full;
        assign pop  = gnt_valid && (gnt_port == RW'(p));

        always_ff @(posedge c_clk or posedge reset) begin
            if (reset) begin
                busy    <= 1'b0;
                cap_cmd <= '0;
                cap_tag <= '0;
                cap_op1 <= '0;
                wp      <= '0;
                rp      <= '0;
                cnt     <= '0;
                ovf     <= 1'b0;
            end else begin
                if (busy) begin
                    busy <= 1'b0;
                end else if (cmd != 4'd0) begin
                    busy    <= 1'b1;
                    cap_cmd <= cmd;
                    cap_tag <= req_tag_in[p*TAG_W +: TAG_W];
                    cap_op1 <= req_data_in[p*DATA_W +: DATA_W];
                end
                if (busy && full) ovf <= 1'b1;
                if (push) wp <= wp + PW'(1);
                if (pop) rp <= rp + PW'(1);
                if (push && !pop) cnt <= cnt + (PW+1)'(1);
                else if (!push && pop) cnt <= cnt - (PW+1)'(1);
            end
        end

        always_ff @(posedge c_clk) begin
            if (push) begin
                m_cmd[wp] <= cap_cmd;
                m_tag[wp] <= cap_tag;
                m_op1[wp] <= cap_op1;
                m_op2[wp] <= req_data_in[p*DATA_W +: DATA_W];
            end
        end

        assign nonempty[p] = (cnt != '0);
        assign head_cmd[p] = m_cmd[rp];
        assign head_tag[p] = m_tag[rp];
        assign head_op1[p] = m_op1[rp];
        assign head_op2[p] = m_op2[rp];
        assign q_ovf[p]    = ovf;
    end

    always_comb begin
        int            k;
        logic [RW-1:0] idx;
        k         = 0;
        idx       = '0;
        gnt_valid = 1'b0;
        gnt_port  = '0;
        for (int i = 0; i < NPORTS; i++) begin
            k   = (int'(rr) + i) % NPORTS;
            idx = RW'(k);
            if (!gnt_valid && nonempty[idx]) begin
                gnt_valid = 1'b1;
                gnt_port  = idx;
            end
        end
    end

    logic [3:0]        x_cmd;
    logic [TAG_W-1:0]  x_tag;
    logic [DATA_W-1:0] x_op1;
    logic [DATA_W-1:0] x_op2;
    logic [DATA_W:0]   x_sum;
    logic [DATA_W-1:0] x_data;
    logic [1:0]        x_resp;

    always_comb begin
        x_cmd  = head_cmd[gnt_port];
        x_tag  = head_tag[gnt_port];
        x_op1  = head_op1[gnt_port];
        x_op2  = head_op2[gnt_port];
        x_sum  = {1'b0, x_op1} + {1'b0, x_op2};
        x_resp = RESP_ERR;
        x_data = '0;
        case (x_cmd)
            4'd1: begin
                if (!x_sum[DATA_W]) begin
                    x_resp = RESP_OK;
                    x_data = x_sum[DATA_W-1:0];
                end
            end
            4'd2: begin
                if (x_op2 <= x_op1) begin
                    x_resp = RESP_OK;
                    x_data = x_op1 - x_op2;
                end
            end
            4'd5: begin
                x_resp = RESP_OK;
                x_data = x_op1 << x_op2[SW-1:0];
            end
            4'd6: begin
                x_resp = RESP_OK;
                x_data = x_op1 >> x_op2[SW-1:0];
            end
            default: begin
                x_resp = RESP_ERR;
                x_data = '0;
            end
        endcase
    end

    logic              rsp_valid;
    logic [RW-1:0]     rsp_port;
    logic [1:0]        rsp_resp;
    logic [DATA_W-1:0] rsp_data;
    logic [TAG_W-1:0]  rsp_tag;

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            rr        <= '0;
            rsp_valid <= 1'b0;
            rsp_port  <= '0;
            rsp_resp  <= '0;
            rsp_data  <= '0;
            rsp_tag   <= '0;
        end else begin
            rsp_valid <= gnt_valid;
            if (gnt_valid) begin
                rsp_port <= gnt_port;
                rsp_resp <= x_resp;
                rsp_data <= x_data;
                rsp_tag  <= x_tag;
                rr <= (gnt_port == RW'(NPORTS-1)) ? '0 : gnt_port + RW'(1);
            end
        end
    end

    always_comb begin
        out_resp = '0;
        out_data = '0;
        out_tag  = '0;
        if (rsp_valid) begin
            out_resp[rsp_port*2 +: 2]           = rsp_resp;
            out_data[rsp_port*DATA_W +: DATA_W] = rsp_data;
            out_tag[rsp_port*TAG_W +: TAG_W]    = rsp_tag;
        end
    end

endmodule

// File: tb/tb_calc_nport_core.sv
// Directed self-checking bench for calc_nport_core.
// A shallow queue depth lets the contention scenario reach overflow.
module tb_calc_nport_core;
    localparam int NP = 4;
    localparam int DW = 32;
    localparam int TW = 2;
    localparam int QD = 2;
    localparam int VW = NP*2 + NP*DW + NP*TW;

    logic           clk = 1'b0;
    logic           rst;
    logic [NP*4-1:0]  cmd;
    logic [NP*DW-1:0] data;
    logic [NP*TW-1:0] tag;
    logic [NP*2-1:0]  out_resp;
    logic [NP*DW-1:0] out_data;
    logic [NP*TW-1:0] out_tag;
    logic [NP-1:0]    q_ovf;
    logic [VW-1:0]    got;
    logic [VW-1:0]    exp;
    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    calc_nport_core #(
        .NPORTS(NP), .DATA_W(DW), .TAG_W(TW), .QDEPTH(QD)
    ) dut (
        .c_clk(clk), .reset(rst),
        .req_cmd_in(cmd), .req_data_in(data), .req_tag_in(tag),
        .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
        .q_ovf(q_ovf)
    );

    assign got = {out_resp, out_data, out_tag};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cmd = '0;
        tag = '0;
        data = '0;
    endtask

    task automatic drive(input int p, input logic [3:0] c,
                         input logic [TW-1:0] t, input logic [DW-1:0] d);
        cmd[p*4 +: 4] = c;
        tag[p*TW +: TW] = t;
        data[p*DW +: DW] = d;
    endtask

    function automatic logic [VW-1:0] one_rsp(input int p, input logic [1:0] r,
                                             input logic [DW-1:0] d,
                                             input logic [TW-1:0] t);
        logic [NP*2-1:0]  vr;
        logic [NP*DW-1:0] vd;
        logic [NP*TW-1:0] vt;
        vr = '0;
        vd = '0;
        vt = '0;
        vr[p*2 +: 2] = r;
        vd[p*DW +: DW] = d;
        vt[p*TW +: TW] = t;
        return {vr, vd, vt};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        idle();
        step();
        step();
        total++;
        if (got !== '0) $display("FAIL reset_out: got %h want 0", got);
        else passed++;
        total++;
        if (q_ovf !== '0) $display("FAIL reset_ovf: got %b want 0", q_ovf);
        else passed++;
        rst = 1'b0;
        step();
        total++;
        if (got !== '0) $display("FAIL post_reset_out: got %h want 0", got);
        else passed++;
    endtask

    task automatic test_add();
        step(); idle(); drive(0, 4'd1, 2'd1, 32'h10);
        step(); idle(); drive(0, 4'd0, 2'd0, 32'h20);
        step(); idle();
        total++;
        if (got !== '0) $display("FAIL add_t2: got %h want 0", got);
        else passed++;
        step();
        exp = one_rsp(0, 2'd1, 32'h30, 2'd1);
        total++;
        if (got !== exp) $display("FAIL add_t3: got %h want %h", got, exp);
        else passed++;
        step();
        total++;
        if (got !== '0) $display("FAIL add_t4: got %h want 0", got);
        else passed++;
    endtask

    task automatic test_alu();
        logic [3:0]  c [7] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd2, 4'd1, 4'd2};
        logic [31:0] a [7] = '{32'hFFFF_FFFF, 32'd3, 32'd1, 32'h8000_0000,
                               32'd5, 32'hFFFF_FFFE, 32'd7};
        logic [31:0] b [7] = '{32'd1, 32'd5, 32'h21, 32'd31, 32'd3, 32'd1, 32'd7};
        logic [1:0]  r [7] = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
        logic [31:0] d [7] = '{32'd0, 32'd0, 32'd2, 32'd1, 32'd2,
                               32'hFFFF_FFFF, 32'd0};
        for (int i = 0; i < 7; i++) begin
            step(); idle(); drive(1, c[i], TW'(i), a[i]);
            step(); idle(); drive(1, 4'd0, 2'd0, b[i]);
            step(); idle();
            step();
            exp = one_rsp(1, r[i], d[i], TW'(i));
            total++;
            if (got !== exp) $display("FAIL alu_%0d: got %h want %h", i, got, exp);
            else passed++;
        end
    endtask

    task automatic test_cmd9();
        step(); idle(); drive(3, 4'd9, 2'd2, 32'h1234);
        step(); idle(); drive(3, 4'd0, 2'd0, 32'h5678);
        step(); idle();
        step();
        exp = one_rsp(3, 2'd2, 32'd0, 2'd2);
        total++;
        if (got !== exp) $display("FAIL cmd9: got %h want %h", got, exp);
        else passed++;
    endtask

    task automatic test_all_ports();
        logic [31:0] a [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        logic [31:0] b [4] = '{32'h1, 32'h2, 32'h3, 32'h4};
        logic [31:0] s [4] = '{32'h12, 32'h24, 32'h36, 32'h48};
        step(); idle();
        for (int p = 0; p < NP; p++) drive(p, 4'd1, TW'(p), a[p]);
        step(); idle();
        for (int p = 0; p < NP; p++) drive(p, 4'd0, 2'd0, b[p]);
        step(); idle();
        total++;
        if (got !== '0) $display("FAIL all_t2: got %h want 0", got);
        else passed++;
        for (int p = 0; p < NP; p++) begin
            step();
            exp = one_rsp(p, 2'd1, s[p], TW'(p));
            total++;
            if (got !== exp) $display("FAIL all_p%0d: got %h want %h", p, got, exp);
            else passed++;
        end
        step();
        total++;
        if (got !== '0) $display("FAIL all_t7: got %h want 0", got);
        else passed++;
    endtask

    // Ports 0..2 hold cmd=1 for 8 cycles: four requests each.
    // Port 2's fourth request meets a full queue and is dropped.
    task automatic test_back_to_back();
        for (int c = 0; c <= 14; c++) begin
            step(); idle();
            if (c <= 7) begin
                for (int p = 0; p < 3; p++) begin
                    if (c % 2 == 0) drive(p, 4'd1, TW'(c/2), 32'(32'h100*p + c/2));
                    else drive(p, 4'd1, 2'd0, 32'd1);
                end
            end
            if (c >= 3 && c <= 13)
                exp = one_rsp((c-3) % 3, 2'd1,
                              32'(32'h100*((c-3) % 3) + (c-3)/3 + 1),
                              TW'((c-3)/3));
            else
                exp = '0;
            total++;
            if (got !== exp) $display("FAIL b2b_c%0d: got %h want %h", c, got, exp);
            else passed++;
            if (c == 7) begin
                total++;
                if (q_ovf !== 4'b0000) $display("FAIL ovf_before: got %b want 0000", q_ovf);
                else passed++;
            end
            if (c == 8) begin
                total++;
                if (q_ovf !== 4'b0100) $display("FAIL ovf_after: got %b want 0100", q_ovf);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid();
        step(); idle();
        drive(0, 4'd1, 2'd0, 32'd5);
        drive(1, 4'd1, 2'd1, 32'd6);
        step(); idle();
        drive(0, 4'd0, 2'd0, 32'd1);
        drive(1, 4'd0, 2'd0, 32'd1);
        drive(3, 4'd1, 2'd3, 32'd9);
        step(); idle();
        rst = 1'b1;
        #1;
        total++;
        if (got !== '0) $display("FAIL rmid_out: got %h want 0", got);
        else passed++;
        total++;
        if (q_ovf !== '0) $display("FAIL rmid_ovf: got %b want 0", q_ovf);
        else passed++;
        step();
        rst = 1'b0;
        idle();
        drive(0, 4'd1, 2'd3, 32'd7);
        drive(3, 4'd0, 2'd0, 32'hAA);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin
                step(); idle();
                if (c == 1) drive(0, 4'd0, 2'd0, 32'd8);
            end
            exp = (c == 3) ? one_rsp(0, 2'd1, 32'd15, 2'd3) : '0;
            total++;
            if (got !== exp) $display("FAIL rmid_c%0d: got %h want %h", c, got, exp);
            else passed++;
        end
        total++;
        if (q_ovf !== '0) $display("FAIL rmid_ovf_end: got %b want 0", q_ovf);
        else passed++;
    endtask

    initial begin
        idle();
        test_reset();
        test_add();
        test_alu();
        test_cmd9();
        test_all_ports();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/calc_nport_core.md
CALC_NPORT_CORE -- requirements
Module: calc_nport_core

Interface
REQ-001 The block SHALL have parameter NPORTS, default 4: number of request/response ports, range 2..8.
REQ-002 The block SHALL have parameter DATA_W, default 32: operand/result width, a power of two and at least 8.
REQ-003 The block SHALL have parameter TAG_W, default 2: tag width per request.
REQ-004 The block SHALL have parameter QDEPTH, default 4: per-port pending-request queue depth, a power of two.
REQ-005 The block SHALL have port c_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port req_cmd_in, input, NPORTS*4 bits: per-port command, nonzero = request start.
REQ-008 The block SHALL have port req_data_in, input, NPORTS*DATA_W bits: op1 in the command cycle, op2 in the following cycle.
REQ-009 The block SHALL have port req_tag_in, input, NPORTS*TAG_W bits: per-port tag, sampled in the command cycle.
REQ-010 The block SHALL have port out_resp, output, NPORTS*2 bits: per-port response, 0 = none, 1 = success, 2 = error, 3 unused.
REQ-011 The block SHALL have port out_data, output, NPORTS*DATA_W bits: per-port result.
REQ-012 The block SHALL have port out_tag, output, NPORTS*TAG_W bits: per-port echoed tag.
REQ-013 The block SHALL have port q_ovf, output, NPORTS bits: per-port sticky queue-overflow flag.

Function
REQ-014 Per port, a nonzero cmd in cycle t SHALL capture cmd, tag and op1; req_data_in in cycle t+1 SHALL be captured as op2; cmd in cycle t+1 SHALL be ignored (two-cycle request).
REQ-015 The completed request SHALL be written to that port's FIFO at the end of cycle t+1.
REQ-016 If that port's FIFO is full at the write, the request SHALL be dropped and q_ovf[p] set, held until reset.
REQ-017 Each cycle a round-robin arbiter SHALL grant exactly one non-empty FIFO, searching from pointer rr; after granting p, rr becomes (p+1) mod NPORTS; rr SHALL be 0 after reset.
REQ-018 The granted entry SHALL be popped and executed that cycle; the result SHALL be registered and appear on port p outputs for exactly one cycle on the next cycle.
REQ-019 Uncontended latency SHALL be: cmd at cycle t gives the response in cycle t+3.
REQ-020 A FIFO write and a grant/pop on the same port in the same cycle SHALL both occur; full-status SHALL be evaluated before that cycle's pop.
REQ-021 cmd 1 (add) SHALL return op1+op2 modulo 2^DATA_W with resp 1; a carry-out SHALL give resp 2 with data 0.
REQ-022 cmd 2 (sub) SHALL return op1-op2 with resp 1; op2>op1 (unsigned) SHALL give resp 2 with data 0.
REQ-023 cmd 5 (shl) and cmd 6 (shr, logical) SHALL shift op1 by op2[log2(DATA_W)-1:0], upper op2 bits ignored, with resp 1.
REQ-024 Any other nonzero cmd SHALL give resp 2, data 0, and the tag echoed.
REQ-025 At most one port SHALL show a nonzero out_resp in any cycle; non-responding ports SHALL show resp 0, data 0, tag 0.
REQ-026 Responses from one port SHALL return in that port's issue order; tags are not checked for uniqueness.

Reset
REQ-027 While reset is high, all outputs SHALL be 0, all FIFOs empty, all q_ovf cleared, any half-captured request discarded, and rr = 0.
REQ-028 Reset asserted mid-operation SHALL immediately force the REQ-027 state; no response from before reset SHALL appear after deassertion.
REQ-029 The first cycle after deassertion SHALL accept a new command.

Verification
REQ-030 Port 0: add, tag 1, op1 0x10, op2 0x20, idle otherwise -> three cycles later out_resp[0]=1, out_data=0x30, out_tag=1; all other ports 0.
REQ-031 Port 1: add 0xFFFFFFFF + 1 -> resp 2, data 0; port 1: sub 3 - 5 -> resp 2, data 0; port 1: shl 1 by 0x21 -> resp 1, data 2.
REQ-032 All four ports issue add in the same cycle -> responses in cycles t+3..t+6 in port order 0,1,2,3, one port per cycle.
REQ-033 Port 2 issues QDEPTH+2 back-to-back requests while ports 0 and 1 hold continuous contention -> q_ovf[2]=1 on the first dropped request; surviving port 2 responses stay in issue order.
REQ-034 cmd 9 on port 3, tag 2 -> resp 2, data 0, tag 2.
REQ-035 Reset pulsed between a request's op1 and op2 cycles with other FIFOs non-empty -> no response appears; q_ovf=0; a fresh add completes with latency 3.
